// File: rtl/gcm_viewer_pkg.sv
// gcm_viewer_pkg: shared types and constants for the GCM result viewer.
//   FRAMES          - number of display frames (one per tag/ciphertext byte)
//   frame_idx_t     - frame index type, 0..FRAMES-1
//   viewer_state_t  - viewer FSM state encoding
package gcm_viewer_pkg;

    localparam int FRAMES = 16;

    typedef logic [3:0] frame_idx_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_SHOW   = 2'd1,
        ST_FROZEN = 2'd2
    } viewer_state_t;

endpackage

// File: rtl/rise_detect.sv
// rise_detect: single-cycle pulse on a 0->1 transition of a level input.
// The delayed copy clears to 0 in reset, so a level that is already high
// when reset releases produces a pulse on the first active cycle.
// Ports:
//   clk        - system clock
//   i_reset_n  - synchronous active-low reset
//   i_level    - level input being watched
//   o_pulse    - high for the cycle where i_level=1 and its delayed copy is 0
module rise_detect (
    input  logic clk,
    input  logic i_reset_n,
    input  logic i_level,
    output logic o_pulse
);

    logic tag_ready_q;

    // One-cycle delayed copy of the level input.
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            tag_ready_q <= 1'b0;
        end else begin
            tag_ready_q <= i_level;
        end
    end

    assign o_pulse = i_level & ~tag_ready_q;

endmodule

// File: rtl/gcm_result_viewer.sv
// gcm_result_viewer: captures the gcm_aes ciphertext and tag on the rising
// edge of o_tag_ready, then steps through 16 frames of {tag byte, ct byte}
// for the seven-segment display driver, DWELL_CYCLES clocks per frame.
// Optional build macro: GCM_VIEWER_TAG_COMPARE_EN enables the captured-tag
// comparison on o_tag_match; otherwise o_tag_match is tied low.
// Ports:
//   clk            - system clock
//   i_reset_n      - synchronous active-low reset
//   i_tag_ready    - gcm_aes result-ready level
//   i_tag          - gcm_aes tag (byte 0 = bits [0:7])
//   i_cipher_text  - gcm_aes ciphertext (byte 0 = bits [0:7])
//   i_hold         - freezes frame advance while high
//   i_expected_tag - reference tag for the optional comparison
//   o_word         - current frame {tag byte, ct byte}
//   o_index        - current frame number 0..15
//   o_valid        - a result has been captured
//   o_tag_match    - captured tag equalled i_expected_tag at capture
module gcm_result_viewer
    import gcm_viewer_pkg::*;
#(
    parameter int DWELL_CYCLES = 25_000_000
) (
    input  logic         clk,
    input  logic         i_reset_n,
    input  logic         i_tag_ready,
    input  logic [0:127] i_tag,
    input  logic [0:127] i_cipher_text,
    input  logic         i_hold,
    input  logic [0:127] i_expected_tag,
    output logic [0:15]  o_word,
    output logic [3:0]   o_index,
    output logic         o_valid,
    output logic         o_tag_match
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam frame_idx_t IDX_LAST = frame_idx_t'(FRAMES - 1);

    logic             capture_s;
    viewer_state_t    state_r;
    frame_idx_t       idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic [0:127]     tag_r;
    logic [0:127]     ct_r;
    logic [0:15]      word_s;
    logic [6:0]       bit_base_s;

    rise_detect u_rise_detect (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .i_level   (i_tag_ready),
        .o_pulse   (capture_s)
    );

    // Capture registers, dwell counter, frame index and viewer FSM.
    // A capture outranks both hold and terminal count. Hold is a per-edge
    // gate: the edge that samples i_hold=1 does not count, and the edge that
    // samples i_hold=0 counts again, so a frozen frame resumes mid-dwell.
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state_r <= ST_EMPTY;
            idx_r   <= 4'd0;
            cnt_r   <= '0;
            tag_r   <= 128'd0;
            ct_r    <= 128'd0;
        end else if (capture_s) begin
            tag_r   <= i_tag;
            ct_r    <= i_cipher_text;
            idx_r   <= 4'd0;
            cnt_r   <= '0;
            state_r <= i_hold ? ST_FROZEN : ST_SHOW;
        end else begin
            case (state_r)
                ST_SHOW, ST_FROZEN: begin
                    if (i_hold) begin
                        state_r <= ST_FROZEN;
                    end else begin
                        state_r <= ST_SHOW;
                        if (cnt_r == CNT_LAST) begin
                            cnt_r <= '0;
                            idx_r <= (idx_r == IDX_LAST) ? 4'd0 : idx_r + 4'd1;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_EMPTY: begin
                    state_r <= ST_EMPTY;
                end
                default: begin
                    state_r <= ST_EMPTY;
                    idx_r   <= 4'd0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

`ifdef GCM_VIEWER_TAG_COMPARE_EN
    logic tag_match_r;

    // Latch the tag comparison at each capture; hold it until the next one.
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            tag_match_r <= 1'b0;
        end else if (capture_s) begin
            tag_match_r <= (i_tag == i_expected_tag);
        end else begin
            tag_match_r <= tag_match_r;
        end
    end

    assign o_tag_match = tag_match_r;
`else
    logic unused_expected_tag_s;

    assign unused_expected_tag_s = ^i_expected_tag;
    assign o_tag_match           = 1'b0;
`endif

    // Frame mux: byte k of each register sits at bits [8k +: 8].
    always_comb begin
        word_s     = 16'h0000;
        bit_base_s = {idx_r, 3'b000};
        if (state_r != ST_EMPTY) begin
            word_s = {tag_r[bit_base_s +: 8], ct_r[bit_base_s +: 8]};
        end else begin
            word_s = 16'h0000;
        end
    end

    assign o_word  = word_s;
    assign o_index = idx_r;
    assign o_valid = (state_r != ST_EMPTY);

endmodule

// File: tb/tb_gcm_result_viewer.sv
// Directed testbench for gcm_result_viewer with DWELL_CYCLES=4.
module tb_gcm_result_viewer;

    logic         clk;
    logic         i_reset_n;
    logic         i_tag_ready;
    logic [0:127] i_tag;
    logic [0:127] i_cipher_text;
    logic         i_hold;
    logic [0:127] i_expected_tag;
    logic [0:15]  o_word;
    logic [3:0]   o_index;
    logic         o_valid;
    logic         o_tag_match;

    int n_pass;
    int n_total;

`ifdef GCM_VIEWER_TAG_COMPARE_EN
    localparam logic EXP_MATCH_EQ = 1'b1;
`else
    localparam logic EXP_MATCH_EQ = 1'b0;
`endif

    localparam logic [0:127] TAG1 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [0:127] CT1  = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    localparam logic [0:127] TAG2 = 128'hFFEEDDCCBBAA99887766554433221100;
    localparam logic [0:127] CT2  = 128'h0123456789ABCDEF0123456789ABCDEF;

    gcm_result_viewer #(
        .DWELL_CYCLES (4)
    ) dut (
        .clk            (clk),
        .i_reset_n      (i_reset_n),
        .i_tag_ready    (i_tag_ready),
        .i_tag          (i_tag),
        .i_cipher_text  (i_cipher_text),
        .i_hold         (i_hold),
        .i_expected_tag (i_expected_tag),
        .o_word         (o_word),
        .o_index        (o_index),
        .o_valid        (o_valid),
        .o_tag_match    (o_tag_match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        i_reset_n      = 1'b0;
        i_tag_ready    = 1'b0;
        i_hold         = 1'b0;
        i_tag          = TAG1;
        i_cipher_text  = CT1;
        i_expected_tag = TAG1;

        // 1. Reset for 3 cycles, then stay EMPTY for 20 cycles.
        step(3);
        chk("rst_word",  32'(o_word),      32'h0000);
        chk("rst_index", 32'(o_index),     32'd0);
        chk("rst_valid", 32'(o_valid),     32'd0);
        chk("rst_match", 32'(o_tag_match), 32'd0);
        i_reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("empty_valid", 32'(o_valid), 32'd0);
        end
        chk("empty_word", 32'(o_word), 32'h0000);

        // 2. Capture and walk.
        i_tag_ready = 1'b1;
        step(1);
        i_tag_ready = 1'b0;
        chk("cap_valid", 32'(o_valid),     32'd1);
        chk("cap_index", 32'(o_index),     32'd0);
        chk("cap_word",  32'(o_word),      32'h00A0);
        chk("cap_match", 32'(o_tag_match), 32'(EXP_MATCH_EQ));
        step(3);
        chk("dwell_end_index", 32'(o_index), 32'd0);
        step(1);
        chk("f1_index", 32'(o_index), 32'd1);
        chk("f1_word",  32'(o_word),  32'h11A1);
        step(59);
        chk("f15_index", 32'(o_index), 32'd15);
        chk("f15_word",  32'(o_word),  32'hFFAF);
        step(1);
        chk("wrap_index", 32'(o_index), 32'd0);
        chk("wrap_word",  32'(o_word),  32'h00A0);

        // 3. Hold at index 5, count 2, for 10 cycles.
        step(22);
        chk("pre_hold_index", 32'(o_index), 32'd5);
        i_hold = 1'b1;
        step(10);
        chk("hold_index", 32'(o_index), 32'd5);
        chk("hold_word",  32'(o_word),  32'h55A5);
        chk("hold_valid", 32'(o_valid), 32'd1);
        i_hold = 1'b0;
        step(1);
        chk("release1_index", 32'(o_index), 32'd5);
        step(1);
        chk("release2_index", 32'(o_index), 32'd6);
        chk("release2_word",  32'(o_word),  32'h66A6);

        // 4. Recapture at index 9 on terminal count.
        step(15);
        chk("f9_index", 32'(o_index), 32'd9);
        chk("f9_word",  32'(o_word),  32'h99A9);
        i_tag          = TAG2;
        i_cipher_text  = CT2;
        i_expected_tag = TAG2;
        i_tag_ready    = 1'b1;
        step(1);
        i_tag_ready = 1'b0;
        chk("recap_index", 32'(o_index),     32'd0);
        chk("recap_word",  32'(o_word),      32'hFF01);
        chk("recap_match", 32'(o_tag_match), 32'(EXP_MATCH_EQ));
        step(4);
        chk("recap_f1_index", 32'(o_index), 32'd1);
        chk("recap_f1_word",  32'(o_word),  32'hEE23);

        // 5. Expected tag differs in bit 127, recapture.
        i_expected_tag = TAG2 ^ 128'h1;
        i_tag_ready    = 1'b1;
        step(1);
        i_tag_ready = 1'b0;
        chk("flip_index", 32'(o_index),     32'd0);
        chk("flip_match", 32'(o_tag_match), 32'd0);
        chk("flip_word",  32'(o_word),      32'hFF01);

        // 6. Reset mid-display at index 7, tag_ready high across release.
        step(28);
        chk("f7_index", 32'(o_index), 32'd7);
        chk("f7_word",  32'(o_word),  32'h88EF);
        i_reset_n   = 1'b0;
        i_tag_ready = 1'b1;
        step(1);
        chk("mid_rst_word",  32'(o_word),      32'h0000);
        chk("mid_rst_index", 32'(o_index),     32'd0);
        chk("mid_rst_valid", 32'(o_valid),     32'd0);
        chk("mid_rst_match", 32'(o_tag_match), 32'd0);
        i_reset_n = 1'b1;
        step(1);
        chk("post_rst_valid", 32'(o_valid), 32'd1);
        chk("post_rst_index", 32'(o_index), 32'd0);
        chk("post_rst_word",  32'(o_word),  32'hFF01);
        step(5);
        chk("post_rst_f1_index", 32'(o_index), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
